// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl shared definitions
// request encodings, FSM states, default widths
package sram_ctrl_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;
  localparam logic ENABLE    = 1'b1;

  localparam int SRAM_ADDR_W_DEF = 18;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WSETUP,
    ST_WPULSE,
    ST_WHOLD,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sram_tristate.sv
// sram_tristate: SRAM data pad
// drive-enable gated output, always-visible input
module sram_tristate (
  input  logic        drive_en,
  input  logic [15:0] data_out,
  output logic [15:0] data_in,
  inout  wire  [15:0] pad
);

  assign pad     = drive_en ? data_out : 16'hzzzz;
  assign data_in = pad;

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: single shared memory port responder
// sequences async SRAM reads and setup/pulse/hold writes
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int SRAM_ADDR_W  = SRAM_ADDR_W_DEF,
  parameter int WRITE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   memEnable_i,
  input  logic                   memReadWrite_i,
  input  logic [15:0]            memAddress_i,
  input  logic [15:0]            memDataWrite_i,
  output logic [15:0]            memDataRead_o,
  output logic                   memReady_o,
  output logic                   memBusy_o,
  output logic [SRAM_ADDR_W-1:0] sramAddr_o,
  inout  wire  [15:0]            sramData_io,
  output logic                   sramCE_n_o,
  output logic                   sramOE_n_o,
  output logic                   sramWE_n_o
);

  localparam int CNT_W =
    (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      wdata_q;
  logic [15:0]      bus_rd;
  logic             sample;
  logic             drive_en;
  logic             ce_nx;
  logic             oe_nx;
  logic             we_nx;

  // next state and request sampling, only IDLE looks at inputs
  always_comb begin
    state_nx = state;
    sample   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (memEnable_i == ENABLE) begin
          sample   = 1'b1;
          state_nx = (memReadWrite_i == MEM_READ) ?
                     ST_RD : ST_WSETUP;
        end
      end
      ST_RD:     state_nx = ST_DONE;
      ST_WSETUP: state_nx = ST_WPULSE;
      ST_WPULSE: if (cnt == '0) state_nx = ST_WHOLD;
      ST_WHOLD:  state_nx = ST_DONE;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // strobe values for the state being entered
  always_comb begin
    ce_nx = 1'b1;
    oe_nx = 1'b1;
    we_nx = 1'b1;
    unique case (1'b1)
      state_nx == ST_RD: begin
        ce_nx = 1'b0;
        oe_nx = 1'b0;
      end
      state_nx == ST_WPULSE: begin
        ce_nx = 1'b0;
        we_nx = 1'b0;
      end
      state_nx == ST_WSETUP,
      state_nx == ST_WHOLD: ce_nx = 1'b0;
      default: ;
    endcase
  end

  // state, registered strobes, latched request and read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      sramCE_n_o    <= 1'b1;
      sramOE_n_o    <= 1'b1;
      sramWE_n_o    <= 1'b1;
      sramAddr_o    <= '0;
      wdata_q       <= '0;
      memDataRead_o <= '0;
    end else begin
      state      <= state_nx;
      sramCE_n_o <= ce_nx;
      sramOE_n_o <= oe_nx;
      sramWE_n_o <= we_nx;
      if (sample) begin
        sramAddr_o <= SRAM_ADDR_W'(memAddress_i);
        if (memReadWrite_i == MEM_WRITE)
          wdata_q <= memDataWrite_i;
      end
      if (state == ST_RD)
        memDataRead_o <= bus_rd;
    end
  end

  // WE_n low-window down-counter, loaded on the way into WPULSE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == ST_WSETUP) begin
      cnt <= CNT_W'(WRITE_CYCLES - 1);
    end else if (state == ST_WPULSE && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign drive_en   = (state == ST_WSETUP) ||
                      (state == ST_WPULSE) ||
                      (state == ST_WHOLD);
  assign memReady_o = (state == ST_DONE);
  assign memBusy_o  = (state != ST_IDLE);

  sram_tristate u_pad (
    .drive_en (drive_en),
    .data_out (wdata_q),
    .data_in  (bus_rd),
    .pad      (sramData_io)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench for sram_ctrl
// random reads/writes against an array reference model
`timescale 1ns/1ps
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int AW = 18;
  localparam int W0 = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic        en0 = 1'b0;
  logic        rw = MEM_READ;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        sw_en = 1'b0;
  int          sw_sel = 0;
  logic        en1, en4;

  logic [15:0]   rd0, rd1, rd4;
  logic          rdy0, rdy1, rdy4;
  logic          busy0, busy1, busy4;
  logic [AW-1:0] sa0, sa1, sa4;
  wire  [15:0]   bus0, bus1, bus4;
  logic          ce0, oe0, we0;
  logic          ce1, oe1, we1;
  logic          ce4, oe4, we4;

  assign en1 = sw_en && (sw_sel == 1);
  assign en4 = sw_en && (sw_sel == 4);

  sram_ctrl #(.SRAM_ADDR_W(AW), .WRITE_CYCLES(W0)) dut0 (
    .clk(clk), .rst(rst),
    .memEnable_i(en0), .memReadWrite_i(rw),
    .memAddress_i(addr), .memDataWrite_i(wdata),
    .memDataRead_o(rd0), .memReady_o(rdy0),
    .memBusy_o(busy0), .sramAddr_o(sa0),
    .sramData_io(bus0), .sramCE_n_o(ce0),
    .sramOE_n_o(oe0), .sramWE_n_o(we0)
  );

  sram_ctrl #(.SRAM_ADDR_W(AW), .WRITE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .memEnable_i(en1), .memReadWrite_i(rw),
    .memAddress_i(addr), .memDataWrite_i(wdata),
    .memDataRead_o(rd1), .memReady_o(rdy1),
    .memBusy_o(busy1), .sramAddr_o(sa1),
    .sramData_io(bus1), .sramCE_n_o(ce1),
    .sramOE_n_o(oe1), .sramWE_n_o(we1)
  );

  sram_ctrl #(.SRAM_ADDR_W(AW), .WRITE_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst),
    .memEnable_i(en4), .memReadWrite_i(rw),
    .memAddress_i(addr), .memDataWrite_i(wdata),
    .memDataRead_o(rd4), .memReady_o(rdy4),
    .memBusy_o(busy4), .sramAddr_o(sa4),
    .sramData_io(bus4), .sramCE_n_o(ce4),
    .sramOE_n_o(oe4), .sramWE_n_o(we4)
  );

  // async SRAM chip model for dut0
  logic [15:0] chip [0:65535];
  logic [15:0] chip_q;
  assign chip_q = chip[sa0[15:0]];
  assign bus0 = (!ce0 && !oe0 && we0) ? chip_q : 16'hzzzz;
  always @(posedge we0) chip[sa0[15:0]] <= bus0;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] expv);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, expv);
    end
  endtask

  // reference model and scoreboard
  typedef struct {
    logic        is_rd;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] wd;
    int          t;
  } exp_t;

  exp_t        q[$];
  logic [15:0] ref_mem [logic [15:0]];
  logic [15:0] waddrs[$];
  logic [15:0] last_rd = '0;

  // monitor: pop and compare on every ready pulse
  exp_t me;
  int   mlat;
  always @(negedge clk) begin
    if (rst && rdy0) begin
      if (q.size() == 0) begin
        chk(1'b0, "spurious_ready", 32'd1, 32'd0);
      end else begin
        me   = q.pop_front();
        mlat = cyc - me.t + 1;
        chk(mlat == (me.is_rd ? 2 : 3 + W0), "latency",
            mlat, me.is_rd ? 2 : 3 + W0);
        chk(rd0 == me.data, "rdata", rd0, me.data);
        chk(sa0 == {2'b00, me.addr}, "sram_addr",
            sa0, {2'b00, me.addr});
        chk(busy0 == 1'b1, "busy_in_done", busy0, 1);
        if (!me.is_rd)
          chk(chip[me.addr] == me.wd, "landed",
              chip[me.addr], me.wd);
      end
    end
  end

  // WE_n window: width, address/data stability around it
  logic          pwe = 1'b1;
  logic [15:0]   pbus = '0;
  logic [AW-1:0] psa = '0;
  int            wlen = 0;
  always @(negedge clk) begin
    if (!rst) begin
      pwe  <= 1'b1;
      wlen <= 0;
    end else begin
      if (!we0) begin
        chk(bus0 == pbus, "we_data_stable", bus0, pbus);
        chk(sa0 == psa, "we_addr_stable", sa0, psa);
        chk(!ce0, "ce_in_pulse", ce0, 0);
        wlen <= wlen + 1;
      end else if (!pwe) begin
        chk(bus0 == pbus, "data_hold", bus0, pbus);
        chk(wlen == W0, "we_width", wlen, W0);
        wlen <= 0;
      end
      pwe  <= we0;
      pbus <= bus0;
      psa  <= sa0;
    end
  end

  task automatic issue(input bit is_rd,
                       input logic [15:0] a,
                       input logic [15:0] d,
                       input bit perturb);
    exp_t e;
    bit   done;
    @(negedge clk);
    en0   = 1'b1;
    rw    = is_rd ? MEM_READ : MEM_WRITE;
    addr  = a;
    wdata = d;
    e.is_rd = is_rd;
    e.addr  = a;
    e.wd    = d;
    e.t     = cyc + 1;
    if (is_rd) begin
      last_rd = ref_mem[a];
    end else begin
      if (!ref_mem.exists(a)) waddrs.push_back(a);
      ref_mem[a] = d;
    end
    e.data = last_rd;
    q.push_back(e);
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (k == 0) chk(busy0, "busy_after_sample", busy0, 1);
      if (rdy0) begin
        done = 1'b1;
      end else if (perturb && k == 1) begin
        addr  = 16'h5555;
        wdata = ~d;
        rw    = ~rw;
      end
    end
    if (!done) chk(1'b0, "ready_timeout", 0, 1);
    @(posedge clk);
    #1 en0 = 1'b0;
  endtask

  // WRITE_CYCLES sweep instances
  logic        rdy_s, we_s, ce_s, oe_s;
  logic [15:0] bus_s, rd_s;
  always_comb begin
    if (sw_sel == 1) begin
      rdy_s = rdy1; we_s = we1; ce_s = ce1;
      oe_s = oe1; bus_s = bus1; rd_s = rd1;
    end else begin
      rdy_s = rdy4; we_s = we4; ce_s = ce4;
      oe_s = oe4; bus_s = bus4; rd_s = rd4;
    end
  end

  task automatic sweep(input int sel, input int w);
    int lowcnt;
    int lat;
    bit got;
    sw_sel = sel;
    @(negedge clk);
    sw_en = 1'b1;
    rw    = MEM_WRITE;
    addr  = 16'h0ABC;
    wdata = 16'h3C3C;
    @(posedge clk);
    lowcnt = 0;
    lat    = 0;
    got    = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(posedge clk);
      #1;
      if (!we_s) begin
        lowcnt++;
        chk(bus_s == 16'h3C3C && !ce_s && oe_s,
            "sweep_pulse", bus_s, 16'h3C3C);
      end
      if (rdy_s) begin
        got = 1'b1;
        lat = k + 1;
      end
    end
    chk(got, "sweep_timeout", got, 1);
    chk(lat == 3 + w, "sweep_latency", lat, 3 + w);
    chk(lowcnt == w, "sweep_we_width", lowcnt, w);
    chk(rd_s == 16'h0000, "sweep_rd_unchanged", rd_s, 0);
    @(posedge clk);
    #1 sw_en = 1'b0;
  endtask

  function automatic logic [15:0] pick();
    logic [3:0] lo;
    lo = 4'($urandom_range(0, 15));
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return {12'h123, lo};
    endcase
  endfunction

  initial begin
    bit          rd;
    logic [15:0] a;
    logic [15:0] d;
    repeat (3) @(negedge clk);
    chk(rdy0 == 1'b0, "rst_ready", rdy0, 0);
    chk(busy0 == 1'b0, "rst_busy", busy0, 0);
    chk(ce0 && oe0 && we0, "rst_strobes",
        {ce0, oe0, we0}, 3'b111);
    chk(rd0 == 16'h0, "rst_rdata", rd0, 0);
    chk(sa0 == '0, "rst_addr", sa0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    issue(1'b0, 16'h1234, 16'hBEEF, 1'b0);
    issue(1'b1, 16'h1234, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    chk(rd0 == 16'hBEEF, "read_held", rd0, 16'hBEEF);

    issue(1'b0, 16'h0000, 16'h0001, 1'b0);
    issue(1'b1, 16'h0000, 16'h0000, 1'b0);
    issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b0);

    issue(1'b0, 16'h1238, 16'h2222, 1'b1);
    issue(1'b1, 16'h1238, 16'h0000, 1'b0);

    // reset in the middle of the WE_n pulse
    @(negedge clk);
    en0   = 1'b1;
    rw    = MEM_WRITE;
    addr  = 16'h7777;
    wdata = 16'hA5A5;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk(we0 == 1'b0, "pre_reset_we", we0, 0);
    rst = 1'b0;
    #1;
    chk(we0 == 1'b1, "async_rst_we", we0, 1);
    chk(ce0 == 1'b1, "async_rst_ce", ce0, 1);
    chk(oe0 == 1'b1, "async_rst_oe", oe0, 1);
    chk(rdy0 == 1'b0, "async_rst_ready", rdy0, 0);
    chk(busy0 == 1'b0, "async_rst_busy", busy0, 0);
    chk(rd0 == 16'h0, "async_rst_rdata", rd0, 0);
    chk(sa0 == '0, "async_rst_addr", sa0, 0);
    en0     = 1'b0;
    last_rd = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk(busy0 == 1'b0, "idle_after_rst", busy0, 0);
    chk(we0 == 1'b1, "we_after_rst", we0, 1);

    for (int i = 0; i < 80; i++) begin
      rd = (waddrs.size() > 0) && ($urandom_range(0, 1) == 1);
      d  = 16'($urandom);
      if (rd) a = waddrs[$urandom_range(0, waddrs.size() - 1)];
      else    a = pick();
      issue(rd, a, d, !rd && ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    sweep(1, 1);
    sweep(4, 4);

    repeat (5) @(negedge clk);
    chk(q.size() == 0, "scoreboard_drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
